// File: rtl/fx_job_sequencer_pkg.sv
// Shared types and memory-map defaults for the float-to-fixed job sequencer.
// The base/length constants must match the core program's data-memory layout.
package fx_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        START,
        RUN,
        UNLOAD_RD,
        UNLOAD_OUT
    } seq_state_t;

    localparam int DEF_LOAD_BASE  = 0;
    localparam int DEF_LOAD_LEN   = 4;
    localparam int DEF_STORE_BASE = 4;
    localparam int DEF_STORE_LEN  = 4;

endpackage

// File: rtl/fx_job_sequencer_if.sv
// Host-side byte streams of the job sequencer: input bytes in, result bytes out.
interface fx_job_sequencer_if;

    logic       job_go;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_ready;

    modport master (
        output job_go, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  job_go, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );

endinterface

// File: rtl/fx_job_sequencer_run_timer.sv
// Cycle counters for the core_start pulse width, the core_done mask window
// and the run timeout. Each counter restarts at 0 on entry to its phase.
module fx_run_timer #(
    parameter int START_CYCLES = 2,
    parameter int DONE_MASK    = 2,
    parameter int TIMEOUT      = 1000
) (
    input  logic clk,
    input  logic reset,
    input  logic start_phase,
    input  logic run_phase,
    output logic start_active,
    output logic done_armed,
    output logic timed_out
);

    localparam int SW = $clog2(START_CYCLES + 1);
    localparam int RW = $clog2(TIMEOUT + 1);

    logic [SW-1:0] start_cnt;
    logic [RW-1:0] run_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            start_cnt <= '0;
            run_cnt   <= '0;
        end else begin
            start_cnt <= start_phase ? start_cnt + SW'(1) : '0;
            run_cnt   <= run_phase ? run_cnt + RW'(1) : '0;
        end
    end

    // start_active means the pulse continues into the following cycle
    assign start_active = start_cnt < SW'(START_CYCLES - 1);
    assign done_armed   = run_cnt >= RW'(DONE_MASK);
    assign timed_out    = run_cnt == RW'(TIMEOUT - 1);

endmodule

// File: rtl/fx_job_sequencer.sv
// Host-side job sequencer: loads input bytes into core data memory, pulses
// core_start, waits for core_done or timeout, then streams the results out.
module fx_job_sequencer import fx_seq_pkg::*; #(
    parameter int AW           = 8,
    parameter int LOAD_BASE    = DEF_LOAD_BASE,
    parameter int LOAD_LEN     = DEF_LOAD_LEN,
    parameter int STORE_BASE   = DEF_STORE_BASE,
    parameter int STORE_LEN    = DEF_STORE_LEN,
    parameter int START_CYCLES = 2,
    parameter int DONE_MASK    = 2,
    parameter int TIMEOUT      = 1000
) (
    input  logic                  clk,
    input  logic                  reset,
    fx_job_sequencer_if.slave     host,
    output logic                  core_start,
    input  logic                  core_done,
    output logic                  mem_sel,
    output logic                  mem_we,
    output logic                  mem_re,
    output logic [AW-1:0]         mem_addr,
    output logic [7:0]            mem_wdata,
    input  logic [7:0]            mem_rdata,
    output logic                  busy,
    output logic                  job_done,
    output logic                  timeout_err
);

    localparam int CW = AW + 1;
    localparam logic [CW-1:0] LOAD_LAST  = CW'(LOAD_LEN - 1);
    localparam logic [CW-1:0] STORE_LAST = CW'(STORE_LEN - 1);

    seq_state_t    state;
    logic [CW-1:0] cnt;
    logic          in_ready_q;
    logic          out_valid_q;
    logic          out_fresh;
    logic [7:0]    out_hold;
    logic          mem_sel_q;
    logic          mem_re_q;
    logic          core_start_q;
    logic          busy_q;
    logic          job_done_q;
    logic          timeout_err_q;
    logic          start_phase;
    logic          run_phase;
    logic          start_active;
    logic          done_armed;
    logic          timed_out;
    logic          load_fire;
    logic          out_fire;

    assign start_phase = (state == START);
    assign run_phase   = (state == RUN);
    assign load_fire   = host.in_valid & in_ready_q;
    assign out_fire    = out_valid_q & host.out_ready;

    fx_run_timer #(
        .START_CYCLES (START_CYCLES),
        .DONE_MASK    (DONE_MASK),
        .TIMEOUT      (TIMEOUT)
    ) u_run_timer (
        .clk          (clk),
        .reset        (reset),
        .start_phase  (start_phase),
        .run_phase    (run_phase),
        .start_active (start_active),
        .done_armed   (done_armed),
        .timed_out    (timed_out)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            cnt           <= '0;
            in_ready_q    <= 1'b0;
            out_valid_q   <= 1'b0;
            out_fresh     <= 1'b0;
            out_hold      <= '0;
            mem_sel_q     <= 1'b1;
            mem_re_q      <= 1'b0;
            core_start_q  <= 1'b0;
            busy_q        <= 1'b0;
            job_done_q    <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            job_done_q <= 1'b0;
            out_fresh  <= 1'b0;
            case (state)
                IDLE: begin
                    if (host.job_go) begin
                        state         <= LOAD;
                        cnt           <= '0;
                        in_ready_q    <= 1'b1;
                        busy_q        <= 1'b1;
                        timeout_err_q <= 1'b0;
                    end
                end
                LOAD: begin
                    if (load_fire) begin
                        cnt <= cnt + CW'(1);
                        if (cnt == LOAD_LAST) begin
                            state        <= START;
                            in_ready_q   <= 1'b0;
                            mem_sel_q    <= 1'b0;
                            core_start_q <= 1'b1;
                        end
                    end
                end
                START: begin
                    if (!start_active) begin
                        state        <= RUN;
                        core_start_q <= 1'b0;
                    end
                end
                RUN: begin
                    // A qualified done wins over a timeout in the same cycle
                    if (core_done && done_armed) begin
                        state     <= UNLOAD_RD;
                        cnt       <= '0;
                        mem_sel_q <= 1'b1;
                        mem_re_q  <= 1'b1;
                    end else if (timed_out) begin
                        state         <= IDLE;
                        mem_sel_q     <= 1'b1;
                        busy_q        <= 1'b0;
                        timeout_err_q <= 1'b1;
                    end
                end
                UNLOAD_RD: begin
                    state       <= UNLOAD_OUT;
                    mem_re_q    <= 1'b0;
                    out_valid_q <= 1'b1;
                    out_fresh   <= 1'b1;
                end
                UNLOAD_OUT: begin
                    if (out_fresh) begin
                        out_hold <= mem_rdata;
                    end
                    if (out_fire) begin
                        out_valid_q <= 1'b0;
                        cnt         <= cnt + CW'(1);
                        if (cnt == STORE_LAST) begin
                            state      <= IDLE;
                            busy_q     <= 1'b0;
                            job_done_q <= 1'b1;
                        end else begin
                            state    <= UNLOAD_RD;
                            mem_re_q <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Read data is forwarded on the entry cycle so a byte can leave every 2 cycles
    assign host.out_data  = out_fresh ? mem_rdata : out_hold;
    assign host.out_valid = out_valid_q;
    assign host.in_ready  = in_ready_q;

    assign mem_we      = load_fire;
    assign mem_re      = mem_re_q;
    assign mem_addr    = mem_we   ? AW'(LOAD_BASE) + cnt[AW-1:0] :
                         mem_re_q ? AW'(STORE_BASE) + cnt[AW-1:0] : '0;
    assign mem_wdata   = mem_we ? host.in_data : '0;
    assign mem_sel     = mem_sel_q;
    assign core_start  = core_start_q;
    assign busy        = busy_q;
    assign job_done    = job_done_q;
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_fx_job_sequencer.sv
// Directed bench for fx_job_sequencer with a synchronous data-memory model
// preloaded with result bytes 0x12,0x34,0x56,0x78 at addresses 4..7.
module tb_fx_job_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       core_start;
    logic       core_done;
    logic       mem_sel;
    logic       mem_we;
    logic       mem_re;
    logic [7:0] mem_addr;
    logic [7:0] mem_wdata;
    logic [7:0] mem_rdata;
    logic       busy;
    logic       job_done;
    logic       timeout_err;
    logic [7:0] mem [256];

    int errors = 0;
    int checks = 0;
    int wr_n = 0;
    int rd_n = 0;
    int out_n = 0;
    int start_hi = 0;
    int done_n = 0;
    int ov_n = 0;
    int bus_viol = 0;
    logic [7:0] wr_addr [64];
    logic [7:0] wr_data [64];
    logic [7:0] rd_addr [64];
    logic [7:0] out_log [64];
    logic [7:0] exp_res [4] = '{8'h12, 8'h34, 8'h56, 8'h78};

    fx_job_sequencer_if hif();

    always #5 clk = ~clk;

    fx_job_sequencer #(
        .AW(8), .LOAD_BASE(0), .LOAD_LEN(4), .STORE_BASE(4), .STORE_LEN(4),
        .START_CYCLES(2), .DONE_MASK(2), .TIMEOUT(1000)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .host        (hif),
        .core_start  (core_start),
        .core_done   (core_done),
        .mem_sel     (mem_sel),
        .mem_we      (mem_we),
        .mem_re      (mem_re),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .busy        (busy),
        .job_done    (job_done),
        .timeout_err (timeout_err)
    );

    // Synchronous data memory: read data appears the cycle after mem_re
    always @(posedge clk) begin
        if (reset) begin
            mem[4]    <= 8'h12;
            mem[5]    <= 8'h34;
            mem[6]    <= 8'h56;
            mem[7]    <= 8'h78;
            mem_rdata <= 8'h00;
        end else begin
            if (mem_sel && mem_we) mem[mem_addr] <= mem_wdata;
            if (mem_sel && mem_re) mem_rdata <= mem[mem_addr];
        end
    end

    // Transaction logger, sampled mid-cycle
    always @(negedge clk) begin
        if (!reset) begin
            if (mem_we) begin
                if (wr_n < 64) begin
                    wr_addr[wr_n] = mem_addr;
                    wr_data[wr_n] = mem_wdata;
                end
                wr_n++;
            end
            if (mem_re) begin
                if (rd_n < 64) rd_addr[rd_n] = mem_addr;
                rd_n++;
            end
            if (hif.out_valid && hif.out_ready) begin
                if (out_n < 64) out_log[out_n] = hif.out_data;
                out_n++;
            end
            if (hif.out_valid) ov_n++;
            if (core_start) start_hi++;
            if (job_done) done_n++;
            if ((mem_we && mem_re) || (!mem_sel && (mem_we || mem_re))) bus_viol++;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic go, input logic iv, input logic [7:0] id,
                                 input logic ordy, input logic done);
        @(posedge clk);
        #1;
        hif.job_go    = go;
        hif.in_valid  = iv;
        hif.in_data   = id;
        hif.out_ready = ordy;
        core_done     = done;
    endtask

    task automatic load_job(input logic [31:0] pat);
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b1, pat[31-8*i -: 8], 1'b0, 1'b0);
    endtask

    task automatic unload_all(input logic done_lvl);
        int n = 0;
        do begin
            applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, done_lvl);
            @(negedge clk);
            n++;
        end while (job_done !== 1'b1 && n < 2000);
        checkOutput("unload_job_done", 32'(job_done), 32'd1);
    endtask

    initial begin
        logic [31:0] pat;
        int wb, rb, ob, db, sb, vb, cyc;

        reset = 1'b1;
        core_done = 1'b0;
        hif.job_go = 1'b0;
        hif.in_valid = 1'b0;
        hif.in_data = 8'h00;
        hif.out_ready = 1'b0;
        $display("[TB] reset");
        repeat (3) applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_mem_sel", 32'(mem_sel), 32'd1);
        checkOutput("rst_in_ready", 32'(hif.in_ready), 32'd0);
        checkOutput("rst_out_valid", 32'(hif.out_valid), 32'd0);
        checkOutput("rst_out_data", 32'(hif.out_data), 32'd0);
        checkOutput("rst_core_start", 32'(core_start), 32'd0);
        checkOutput("rst_job_done", 32'(job_done), 32'd0);
        checkOutput("rst_timeout_err", 32'(timeout_err), 32'd0);
        checkOutput("rst_mem_we_re", 32'({mem_we, mem_re}), 32'd0);
        checkOutput("rst_mem_addr", 32'(mem_addr), 32'd0);
        reset = 1'b0;

        $display("[TB] nominal job");
        wb = wr_n; rb = rd_n; ob = out_n; db = done_n; sb = start_hi;
        pat = 32'h3C00C180;
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 1'b1, pat[31-8*i -: 8], 1'b0, 1'b0);
            @(negedge clk);
            checkOutput("t1_in_ready", 32'(hif.in_ready), 32'd1);
            checkOutput("t1_we_addr", 32'({mem_we, mem_addr}), 32'h100 + 32'(i));
            checkOutput("t1_busy", 32'(busy), 32'd1);
        end
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("t1_start_c1", 32'({core_start, mem_sel, hif.in_ready}), 32'b100);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("t1_start_c2", 32'(core_start), 32'd1);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("t1_run_entry", 32'({core_start, mem_sel, busy}), 32'b001);
        repeat (49) applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        @(negedge clk);
        checkOutput("t1_rd0", 32'({mem_re, mem_sel, mem_addr}), 32'h304);
        unload_all(1'b0);
        #2;
        checkOutput("t1_wr_count", 32'(wr_n - wb), 32'd4);
        checkOutput("t1_rd_count", 32'(rd_n - rb), 32'd4);
        checkOutput("t1_out_count", 32'(out_n - ob), 32'd4);
        checkOutput("t1_start_width", 32'(start_hi - sb), 32'd2);
        checkOutput("t1_done_pulses", 32'(done_n - db), 32'd1);
        for (int i = 0; i < 4; i++) begin
            checkOutput("t1_wr_data", 32'(wr_data[wb+i]), 32'(pat[31-8*i -: 8]));
            checkOutput("t1_rd_addr", 32'(rd_addr[rb+i]), 32'd4 + 32'(i));
            checkOutput("t1_out_data", 32'(out_log[ob+i]), 32'(exp_res[i]));
        end

        $display("[TB] input back-pressure");
        wb = wr_n; ob = out_n;
        pat = 32'h11223344;
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 1'b1, pat[31-8*i -: 8], 1'b0, 1'b0);
            if (i < 3) begin
                applyStimulus(1'b0, 1'b0, 8'hFF, 1'b0, 1'b0);
                @(negedge clk);
                checkOutput("t2_no_write_gap", 32'({hif.in_ready, mem_we}), 32'b10);
                applyStimulus(1'b0, 1'b0, 8'hFF, 1'b0, 1'b0);
            end
        end
        unload_all(1'b1);
        #2;
        checkOutput("t2_wr_count", 32'(wr_n - wb), 32'd4);
        for (int i = 0; i < 4; i++) begin
            checkOutput("t2_wr_addr", 32'(wr_addr[wb+i]), 32'(i));
            checkOutput("t2_wr_data", 32'(wr_data[wb+i]), 32'(pat[31-8*i -: 8]));
            checkOutput("t2_out_data", 32'(out_log[ob+i]), 32'(exp_res[i]));
        end

        $display("[TB] early done and output back-pressure");
        rb = rd_n; ob = out_n;
        load_job(32'hA0B1C2D3);
        for (int i = 1; i <= 5; i++) begin
            applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
            @(negedge clk);
            checkOutput("t3_done_masked", 32'({mem_re, mem_sel}), 32'b00);
        end
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        @(negedge clk);
        checkOutput("t3_rd0_after_mask", 32'({mem_re, mem_addr}), 32'h104);
        repeat (3) applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
            @(negedge clk);
            checkOutput("t3_hold_valid", 32'({hif.out_valid, mem_re}), 32'b10);
            checkOutput("t3_hold_data", 32'(hif.out_data), 32'h56);
        end
        unload_all(1'b0);
        #2;
        checkOutput("t3_rd_count", 32'(rd_n - rb), 32'd4);
        checkOutput("t3_out_count", 32'(out_n - ob), 32'd4);
        checkOutput("t3_out_byte2", 32'(out_log[ob+2]), 32'h56);
        checkOutput("t3_rd_addr3", 32'(rd_addr[rb+3]), 32'd7);

        $display("[TB] timeout");
        db = done_n; rb = rd_n; vb = ov_n;
        load_job(32'h01020304);
        cyc = 0;
        do begin
            applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
            @(negedge clk);
            cyc++;
        end while (busy === 1'b1 && cyc < 1100);
        checkOutput("t4_cycles_to_idle", 32'(cyc), 32'd1003);
        checkOutput("t4_timeout_err", 32'(timeout_err), 32'd1);
        checkOutput("t4_mem_sel", 32'(mem_sel), 32'd1);
        #2;
        checkOutput("t4_no_job_done", 32'(done_n - db), 32'd0);
        checkOutput("t4_no_out_valid", 32'(ov_n - vb), 32'd0);
        checkOutput("t4_no_reads", 32'(rd_n - rb), 32'd0);

        $display("[TB] error clear, ignored job_go, reset mid-unload");
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("t5_err_until_accept", 32'(timeout_err), 32'd1);
        pat = 32'h55AA0F0F;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 1'b1, pat[31-8*i -: 8], 1'b0, 1'b0);
            @(negedge clk);
            checkOutput("t5_err_cleared", 32'(timeout_err), 32'd0);
        end
        repeat (2) applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("t5_go_ignored", 32'({busy, hif.in_ready, mem_sel, core_start}), 32'b1000);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("t5_valid_before_reset", 32'(hif.out_valid), 32'd1);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("t5_reset_flush", 32'({hif.out_valid, busy, mem_sel, mem_re, job_done}), 32'b00100);
        reset = 1'b0;
        #2;
        checkOutput("bus_exclusive", 32'(bus_viol), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fx_job_sequencer.md
Name: fx_job_sequencer

Overview:
- Host-side sequencer directly upstream of the float-to-fixed core's data memory and start/done pins.
- Streams a job's input bytes into data memory and pulses the core's start.
- Waits for the core's done (or a timeout), then streams the result bytes back out to the host.
- Owns the single data-memory port whenever the core is not running; the top level muxes the port on mem_sel.

Parameters:
- AW, 8, data-memory address width.
- LOAD_BASE, 0, first data-memory address written with input bytes.
- LOAD_LEN, 4, number of input bytes per job (1..2^AW).
- STORE_BASE, 4, first data-memory address read for results.
- STORE_LEN, 4, number of result bytes per job (1..2^AW).
- START_CYCLES, 2, width in cycles of the core_start pulse.
- DONE_MASK, 2, cycles after core_start falls during which core_done is ignored.
- TIMEOUT, 1000, maximum run cycles before abort.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- job_go  in  1  single-cycle request to begin a job; sampled only in IDLE
- in_valid  in  1  input byte valid
- in_data  in  8  input byte
- in_ready  out  1  sequencer accepts in_data this cycle
- out_valid  out  1  result byte valid
- out_data  out  8  result byte
- out_ready  in  1  host accepts out_data
- core_start  out  1  core start; the core resets its PC on the falling edge
- core_done  in  1  core completion flag
- mem_sel  out  1  high = sequencer owns the data-memory port
- mem_we  out  1  write strobe
- mem_re  out  1  read strobe; mem_rdata is valid the next cycle
- mem_addr  out  AW  address
- mem_wdata  out  8  write data
- mem_rdata  in  8  read data
- busy  out  1  high in every state except IDLE
- job_done  out  1  one-cycle pulse on normal completion
- timeout_err  out  1  sticky; cleared by the next accepted job_go or by reset

Behaviour:
- Reset: state=IDLE. All outputs 0 except mem_sel=1. Counters=0. Reset applies mid-job from any state; no partial output is flushed.
- IDLE: job_go=1 -> LOAD, clear byte counter, clear timeout_err. job_go in any other state is ignored.
- LOAD:
  - in_ready=1.
  - On in_valid&in_ready: mem_we=1, mem_addr=LOAD_BASE+cnt (mod 2^AW wrap), mem_wdata=in_data, cnt++.
  - Writes are combinational from the handshake, so there is one write per accepted byte and zero extra latency.
  - After the LOAD_LEN-th byte -> START. in_ready drops the cycle after the last accept.
- START:
  - mem_sel=0, core_start=1 for exactly START_CYCLES cycles -> RUN.
  - core_start falls on RUN entry. The run counter starts at 0 that cycle.
- RUN:
  - mem_sel=0. The run counter increments every cycle.
  - core_done is ignored while run counter < DONE_MASK.
  - core_done=1 with counter >= DONE_MASK -> UNLOAD_RD (cnt=0). This takes precedence over timeout in the same cycle.
  - Counter == TIMEOUT-1 with no done -> set timeout_err, go to IDLE, no job_done.
- UNLOAD_RD: mem_sel=1, mem_re=1, mem_addr=STORE_BASE+cnt -> UNLOAD_OUT.
- UNLOAD_OUT:
  - Entry cycle: capture mem_rdata into the out_data register and set out_valid=1.
  - out_data is held stable while out_valid&!out_ready.
  - On out_valid&out_ready: out_valid=0, cnt++.
    - If cnt was STORE_LEN-1 -> IDLE with job_done=1 for one cycle.
    - Otherwise -> UNLOAD_RD.
  - Throughput: one result byte per 2 cycles minimum.
- mem_we and mem_re are never both high. Both are 0 whenever mem_sel=0.
- Counter widths: byte counter AW+1 bits; run counter ceil(log2(TIMEOUT+1)) bits.

Decomposition:
- Package fx_seq_pkg:
  - state enum: IDLE, LOAD, START, RUN, UNLOAD_RD, UNLOAD_OUT.
  - Default LOAD_BASE/STORE_BASE/LEN constants, shared with the program's memory map.
- One natural sub-module: fx_run_timer, holding the start-pulse width, done-mask and timeout counting, with outputs start_active, done_armed, timed_out.

Test Plan:
- Nominal job: job_go, bytes 0x3C,0x00,0xC1,0x80 with in_valid held high -> mem writes to addr 0..3, one per cycle; core_start high 2 cycles; model core_done after 50 cycles; mem_re at addr 4..7; out_data equals the preloaded 0x12,0x34,0x56,0x78; job_done pulses once.
- Input back-pressure: in_valid toggling 1,0,0,1,... -> writes occur only on handshake cycles; addresses contiguous 0..3; no extra writes.
- Output back-pressure: out_ready low for 5 cycles on byte 2 -> out_data stays 0x56 and out_valid stays high; no re-read (mem_re not asserted again until accept).
- Early done: core_done high from cycle 0 of RUN -> ignored for 2 cycles; unload starts after DONE_MASK elapses.
- Timeout: core_done never asserted -> after 1000 RUN cycles timeout_err=1, state IDLE, no out_valid, no job_done; the next job_go clears timeout_err.
- Reset mid-UNLOAD_OUT with out_valid=1 -> next cycle out_valid=0, busy=0, mem_sel=1; job_go during RUN is ignored.
